// File: rtl/pueo_threshold_loader.sv
// Streams one packet of threshold words into the head of a cascaded DSP threshold
// chain, then issues a single update strobe. Optional gap timeout: PUEO_THRESH_LOADER_TIMEOUT_EN.
module pueo_threshold_loader #(
  parameter int NSTAGES     = 16,
  parameter int THRESH_BITS = 18,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2*THRESH_BITS-1:0] s_thresh_tdata,
  input  logic                     s_thresh_tvalid,
  output logic                     s_thresh_tready,
  input  logic                     s_thresh_tlast,
  input  logic                     update_ok_i,
  output logic [2*THRESH_BITS-1:0] thresh_o,
  output logic [1:0]               thresh_wr_o,
  output logic [1:0]               thresh_update_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int CW = $clog2(NSTAGES + 1);
  localparam int WW = 2 * THRESH_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, WAIT_UPD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   count_inc;
  logic [WW-1:0]   thresh_q, thresh_d;
  logic            wr_q, wr_d;
  logic            upd_q, upd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready;
  logic            accept;
  logic            timeout_hit;

  assign ready           = (state_q != WAIT_UPD);
  assign accept          = s_thresh_tvalid & ready;
  assign s_thresh_tready = ready & ~rst_i;

  // Word count including the beat being accepted this cycle.
  assign count_inc = (state_q == IDLE) ? CW'(1) : count_q + CW'(1);

`ifdef PUEO_THRESH_LOADER_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d       = gap_q;
    timeout_hit = 1'b0;
    if (state_q == LOAD || state_q == DRAIN) begin
      if (accept) begin
        gap_d = '0;
      end else if (gap_q == GW'(TIMEOUT - 1)) begin
        timeout_hit = 1'b1;
        gap_d       = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else if (state_q == IDLE) begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) gap_q <= '0;
    else       gap_q <= gap_d;
  end
`else
  // TIMEOUT is only meaningful with the gap counter; a negative value is never valid.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    thresh_d = thresh_q;
    wr_d     = 1'b0;
    upd_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          thresh_d = s_thresh_tdata;
          wr_d     = 1'b1;
          count_d  = count_inc;
          if (s_thresh_tlast) begin
            if (count_inc == CW'(NSTAGES)) begin
              state_d = WAIT_UPD;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
              count_d = '0;
            end
          end else if (count_inc == CW'(NSTAGES)) begin
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end
      end
      DRAIN: begin
        if ((accept && s_thresh_tlast) || timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end
      end
      WAIT_UPD: begin
        // Hold tready low through the update and done pulses so the next
        // packet starts only after done_o.
        if (done_q) begin
          state_d = IDLE;
          count_d = '0;
        end else if (upd_q) begin
          done_d = 1'b1;
        end else if (update_ok_i) begin
          upd_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      thresh_q <= '0;
      wr_q     <= 1'b0;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      wr_q     <= wr_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign thresh_o        = thresh_q;
  assign thresh_wr_o     = {2{wr_q}};
  assign thresh_update_o = {2{upd_q}};
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
